cpu: RTL and testbench

//  Single-cycle 32-bit MIPS-subset processor with private instruction and data memories.

---
 rtl/cpu.sv | 258 +++++++++++++++++++++++++
 tb/tb_cpu.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// cpu: single-cycle 32-bit MIPS-subset core with private instruction and data
// memories. External ports load and read back both memories while the core is
// frozen (enable=0); the core runs one instruction per cycle until STOP.

module regfile #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              arst_n,
    input  logic              wen,
    input  logic [4:0]        waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [4:0]        raddr_a,
    input  logic [4:0]        raddr_b,
    output logic [DATA_W-1:0] rdata_a,
    output logic [DATA_W-1:0] rdata_b
);
    logic [DATA_W-1:0] reg_array [0:31];

    // Architectural registers: cleared on reset, writes to $0 dropped
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            for (int i = 0; i < 32; i++) begin
                reg_array[i] <= '0;
            end
        end else if (wen && (waddr != 5'd0)) begin
            reg_array[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == 5'd0) ? '0 : reg_array[raddr_a];
    assign rdata_b = (raddr_b == 5'd0) ? '0 : reg_array[raddr_b];
endmodule

module cpu #(
    parameter int IMEM_SIZE = 512,
    parameter int DMEM_SIZE = 1024
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        enable,
    input  logic [31:0] addr_ext,
    input  logic        wen_ext,
    input  logic        ren_ext,
    input  logic [31:0] wdata_ext,
    input  logic [31:0] addr_ext_2,
    input  logic        wen_ext_2,
    input  logic        ren_ext_2,
    input  logic [31:0] wdata_ext_2,
    output logic [31:0] rdata_ext,
    output logic [31:0] rdata_ext_2
);
    localparam int DATA_W  = 32;
    localparam int IMEM_AW = $clog2(IMEM_SIZE);
    localparam int DMEM_AW = $clog2(DMEM_SIZE);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_STOP  = 6'b111110;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_MUL = 6'b011000;

    function automatic logic signed [DATA_W-1:0] sext16(input logic [15:0] v);
        return {{(DATA_W-16){v[15]}}, v};
    endfunction

    function automatic logic rtype_known(input logic [5:0] fn);
        return (fn == FN_ADD) || (fn == FN_SUB) || (fn == FN_AND) ||
               (fn == FN_OR)  || (fn == FN_SLT) || (fn == FN_MUL);
    endfunction

    // Results wrap modulo 2^32; mul keeps the low word of the product
    function automatic logic signed [DATA_W-1:0] alu_rtype(
        input logic [5:0]               fn,
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        logic signed [DATA_W-1:0] r;
        r = '0;
        case (fn)
            FN_ADD:  r = a + b;
            FN_SUB:  r = a - b;
            FN_AND:  r = a & b;
            FN_OR:   r = a | b;
            FN_SLT:  r = {{(DATA_W-1){1'b0}}, (a < b)};
            FN_MUL:  r = a * b;
            default: r = '0;
        endcase
        return r;
    endfunction

    logic [DATA_W-1:0]        imem [0:IMEM_SIZE-1];
    logic [DATA_W-1:0]        dmem [0:DMEM_SIZE-1];
    logic [DATA_W-1:0]        pc;
    logic                     halted;
    logic [DATA_W-1:0]        instruction;
    logic [5:0]               opcode;
    logic [5:0]               funct;
    logic [4:0]               rs;
    logic [4:0]               rt;
    logic [4:0]               rd;
    logic [15:0]              imm16;
    logic [25:0]              target;
    logic signed [DATA_W-1:0] imm_sext;
    logic signed [DATA_W-1:0] rs_val;
    logic signed [DATA_W-1:0] rt_val;
    logic signed [DATA_W-1:0] eff_addr;
    logic [DATA_W-1:0]        rf_rdata_a;
    logic [DATA_W-1:0]        rf_rdata_b;
    logic [DATA_W-1:0]        pc_plus4;
    logic [DATA_W-1:0]        pc_next;
    logic                     rf_wen;
    logic [4:0]               rf_waddr;
    logic signed [DATA_W-1:0] rf_wdata;
    logic                     dmem_wen;
    logic                     halt_set;
    logic                     commit;
    logic [IMEM_AW-1:0]       imem_ext_idx;
    logic [IMEM_AW-1:0]       pc_idx;
    logic [DMEM_AW-1:0]       dmem_ext_idx;
    logic [DMEM_AW-1:0]       dmem_idx;
    logic                     unused_bits;

    assign imem_ext_idx = addr_ext[IMEM_AW+1:2];
    assign dmem_ext_idx = addr_ext_2[DMEM_AW+1:2];
    assign pc_idx       = pc[IMEM_AW+1:2];

    assign instruction = imem[pc_idx];
    assign opcode      = instruction[31:26];
    assign rs          = instruction[25:21];
    assign rt          = instruction[20:16];
    assign rd          = instruction[15:11];
    assign funct       = instruction[5:0];
    assign imm16       = instruction[15:0];
    assign target      = instruction[25:0];

    assign imm_sext = sext16(imm16);
    assign rs_val   = rf_rdata_a;
    assign rt_val   = rf_rdata_b;
    assign eff_addr = rs_val + imm_sext;
    assign dmem_idx = eff_addr[DMEM_AW+1:2];
    assign pc_plus4 = pc + 32'd4;

    // Nothing architectural changes during reset, while frozen or once halted
    assign commit = arst_n && enable && !halted;

    assign unused_bits = ^{addr_ext[31:IMEM_AW+2], addr_ext[1:0],
                           addr_ext_2[31:DMEM_AW+2], addr_ext_2[1:0],
                           eff_addr[DATA_W-1:DMEM_AW+2], eff_addr[1:0]};

    regfile #(.DATA_W(DATA_W)) register_file (
        .clk     (clk),
        .arst_n  (arst_n),
        .wen     (commit && rf_wen),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (rs),
        .raddr_b (rt),
        .rdata_a (rf_rdata_a),
        .rdata_b (rf_rdata_b)
    );

    // Decode/execute: next PC and the write-back/store controls for this instruction
    always_comb begin
        pc_next  = pc_plus4;
        rf_wen   = 1'b0;
        rf_waddr = rt;
        rf_wdata = '0;
        dmem_wen = 1'b0;
        halt_set = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                rf_wen   = rtype_known(funct);
                rf_waddr = rd;
                rf_wdata = alu_rtype(funct, rs_val, rt_val);
            end
            OP_ADDI: begin
                rf_wen   = 1'b1;
                rf_wdata = rs_val + imm_sext;
            end
            OP_LW: begin
                rf_wen   = 1'b1;
                rf_wdata = dmem[dmem_idx];
            end
            OP_SW: begin
                dmem_wen = 1'b1;
            end
            OP_BEQ: begin
                if (rs_val == rt_val) begin
                    pc_next = pc_plus4 + (imm_sext <<< 2);
                end
            end
            OP_J: begin
                pc_next = {pc[31:28], target, 2'b00};
            end
            OP_STOP: begin
                pc_next  = pc;
                halt_set = 1'b1;
            end
            default: begin
                pc_next = pc_plus4;
            end
        endcase
    end

    // Program counter and halt flag
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            pc     <= '0;
            halted <= 1'b0;
        end else if (commit) begin
            pc <= pc_next;
            if (halt_set) begin
                halted <= 1'b1;
            end
        end
    end

    // Instruction memory: external writes only while the core is frozen
    always_ff @(posedge clk) begin
        if (!enable && wen_ext) begin
            imem[imem_ext_idx] <= wdata_ext;
        end
    end

    // Data memory: stores from the core when running, external writes when frozen
    always_ff @(posedge clk) begin
        if (commit && dmem_wen) begin
            dmem[dmem_idx] <= rt_val;
        end else if (!enable && wen_ext_2) begin
            dmem[dmem_ext_idx] <= wdata_ext_2;
        end
    end

    // External readback registers: load on a strobe, otherwise hold
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            rdata_ext   <= '0;
            rdata_ext_2 <= '0;
        end else begin
            if (!enable && ren_ext) begin
                rdata_ext <= imem[imem_ext_idx];
            end
            if (!enable && ren_ext_2) begin
                rdata_ext_2 <= dmem[dmem_ext_idx];
            end
        end
    end
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: scoreboard bench for the cpu core. Directed programs plus randomized
// programs are checked against an instruction-level interpreter kept here.

module tb_cpu;
    localparam int IMEM_SIZE = 512;
    localparam int DMEM_SIZE = 1024;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] addr_ext = '0;
    logic        wen_ext = 1'b0;
    logic        ren_ext = 1'b0;
    logic [31:0] wdata_ext = '0;
    logic [31:0] addr_ext_2 = '0;
    logic        wen_ext_2 = 1'b0;
    logic        ren_ext_2 = 1'b0;
    logic [31:0] wdata_ext_2 = '0;
    logic [31:0] rdata_ext;
    logic [31:0] rdata_ext_2;

    always #5 clk = ~clk;

    cpu #(.IMEM_SIZE(IMEM_SIZE), .DMEM_SIZE(DMEM_SIZE)) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .enable      (enable),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .wdata_ext   (wdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .rdata_ext   (rdata_ext),
        .rdata_ext_2 (rdata_ext_2)
    );

    // Snapshot kinds: 0..31 register, 32 pc, 33 rdata_ext, 34 rdata_ext_2, 35 cycle count
    typedef struct {
        int          kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t        rd_q[$];
    exp_t        rd2_q[$];
    exp_t        st_q[$];
    exp_t        me;
    logic [31:0] act;
    int          checks = 0;
    int          failures = 0;
    logic        snap_vld = 1'b0;
    logic        ren_d = 1'b0;
    logic        ren2_d = 1'b0;
    int          meas_cycles = 0;

    logic [31:0] m_imem [IMEM_SIZE];
    logic [31:0] m_dmem [DMEM_SIZE];
    logic [31:0] m_reg  [32];
    logic [31:0] m_pc;
    logic [31:0] prog[$];

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] required);
        checks++;
        if (actual !== required) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, actual, required);
        end
    endtask

    always @(posedge clk) begin
        ren_d  <= ren_ext;
        ren2_d <= ren_ext_2;
    end

    // Monitor: pops an expectation whenever the DUT presents a response
    always @(negedge clk) begin
        if (ren_d) begin
            if (rd_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL imem_read_unexpected actual=%h required=none", rdata_ext);
            end else begin
                me = rd_q.pop_front();
                chk(me.name, rdata_ext, me.val);
            end
        end
        if (ren2_d) begin
            if (rd2_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL dmem_read_unexpected actual=%h required=none", rdata_ext_2);
            end else begin
                me = rd2_q.pop_front();
                chk(me.name, rdata_ext_2, me.val);
            end
        end
        if (snap_vld && st_q.size() != 0) begin
            me = st_q.pop_front();
            case (me.kind)
                32:      act = dut.pc;
                33:      act = rdata_ext;
                34:      act = rdata_ext_2;
                35:      act = 32'(meas_cycles);
                default: act = dut.register_file.reg_array[me.kind[4:0]];
            endcase
            chk(me.name, act, me.val);
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "global timeout");
    end

    // ---------------- encoders ----------------
    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd, input int fn);
        return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'(fn)};
    endfunction
    function automatic logic [31:0] enc_i(input int op, input int rs, input int rt, input int imm);
        return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
    endfunction
    function automatic logic [31:0] enc_j(input int word_target);
        return {6'd2, 26'(word_target)};
    endfunction
    function automatic logic [31:0] enc_stop(input int tag);
        return {6'b111110, 24'd0, 2'(tag)};
    endfunction

    // ---------------- reference interpreter ----------------
    function automatic void wreg(input int r, input logic [31:0] v);
        if (r != 0) m_reg[r] = v;
    endfunction

    task automatic model_run(output int steps);
        logic [31:0] ins, a, b, simm, npc, ea;
        int          op, fn, rs, rt, rd, idx;
        bit          halt;
        steps = 0;
        halt  = 0;
        while (!halt && steps < 10000) begin
            ins  = m_imem[(m_pc >> 2) % IMEM_SIZE];
            op   = int'(ins[31:26]);
            rs   = int'(ins[25:21]);
            rt   = int'(ins[20:16]);
            rd   = int'(ins[15:11]);
            fn   = int'(ins[5:0]);
            a    = m_reg[rs];
            b    = m_reg[rt];
            simm = {{16{ins[15]}}, ins[15:0]};
            ea   = a + simm;
            idx  = int'((ea >> 2) % DMEM_SIZE);
            npc  = m_pc + 4;
            steps++;
            case (op)
                0: case (fn)
                       32: wreg(rd, a + b);
                       34: wreg(rd, a - b);
                       36: wreg(rd, a & b);
                       37: wreg(rd, a | b);
                       42: wreg(rd, ($signed(a) < $signed(b)) ? 32'd1 : 32'd0);
                       24: wreg(rd, a * b);
                       default: ;
                   endcase
                8:  wreg(rt, a + simm);
                35: wreg(rt, m_dmem[idx]);
                43: m_dmem[idx] = b;
                4:  if (a == b) npc = npc + simm * 4;
                2:  npc = {m_pc[31:28], ins[25:0], 2'b00};
                62: begin npc = m_pc; halt = 1; end
                default: ;
            endcase
            m_pc = npc;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic snap(input int kind, input logic [31:0] val, input string name);
        exp_t e;
        e.kind = kind; e.val = val; e.name = name;
        st_q.push_back(e);
        snap_vld = 1'b1;
        tick();
        snap_vld = 1'b0;
    endtask

    task automatic do_reset();
        arst_n = 1'b0; enable = 1'b0;
        wen_ext = 1'b0; ren_ext = 1'b0; wen_ext_2 = 1'b0; ren_ext_2 = 1'b0;
        tick(); tick();
        arst_n = 1'b1;
        m_pc = '0;
        for (int r = 0; r < 32; r++) m_reg[r] = '0;
    endtask

    task automatic imem_write(input int idx, input logic [31:0] d);
        addr_ext = 32'(idx * 4); wdata_ext = d; wen_ext = 1'b1;
        tick();
        wen_ext = 1'b0;
        m_imem[idx] = d;
    endtask

    task automatic dmem_write(input int idx, input logic [31:0] d);
        addr_ext_2 = 32'(idx * 4); wdata_ext_2 = d; wen_ext_2 = 1'b1;
        tick();
        wen_ext_2 = 1'b0;
        m_dmem[idx] = d;
    endtask

    task automatic imem_read(input int idx, input logic [31:0] expv, input string name);
        exp_t e;
        e.kind = 0; e.val = expv; e.name = name;
        rd_q.push_back(e);
        addr_ext = 32'(idx * 4); ren_ext = 1'b1;
        tick();
        ren_ext = 1'b0;
    endtask

    task automatic dmem_read(input int idx, input logic [31:0] expv, input string name);
        exp_t e;
        e.kind = 0; e.val = expv; e.name = name;
        rd2_q.push_back(e);
        addr_ext_2 = 32'(idx * 4); ren_ext_2 = 1'b1;
        tick();
        ren_ext_2 = 1'b0;
    endtask

    task automatic load_prog();
        for (int i = 0; i < prog.size(); i++) imem_write(i, prog[i]);
    endtask

    // Run the loaded program to STOP; with toggle, enable flickers and ignored
    // external writes are thrown at both memories while the core runs.
    task automatic run_prog(input bit toggle, input string tag);
        int  steps, cyc, en_cnt, budget;
        bit  done, en;
        model_run(steps);
        budget = steps * 8 + 50;
        cyc = 0; en_cnt = 0; done = 0;
        while (!done && cyc < budget) begin
            en = toggle ? ($urandom_range(0, 3) != 0) : 1'b1;
            enable = en;
            if (en && toggle) begin
                addr_ext    = 32'($urandom_range(0, prog.size() - 1) * 4);
                wdata_ext   = $urandom();
                wen_ext     = 1'b1;
                addr_ext_2  = 32'($urandom_range(0, 23) * 4);
                wdata_ext_2 = $urandom();
                wen_ext_2   = 1'b1;
            end else begin
                wen_ext = 1'b0; wen_ext_2 = 1'b0;
            end
            tick();
            cyc++;
            if (en) en_cnt++;
            if (dut.halted === 1'b1) done = 1;
        end
        enable = 1'b0; wen_ext = 1'b0; wen_ext_2 = 1'b0;
        tick();
        if (!done) begin
            checks++; failures++;
            $display("FAIL %s_halt_timeout actual=running required=halted", tag);
        end
        meas_cycles = en_cnt;
        snap(35, 32'(steps), {tag, "_cycles"});
        snap(32, m_pc, {tag, "_pc"});
        for (int r = 0; r < 32; r++) snap(r, m_reg[r], $sformatf("%s_reg%0d", tag, r));
    endtask

    function automatic logic [31:0] rand_instr();
        int k, fsel, off;
        int fns[6] = '{32, 34, 36, 37, 42, 24};
        int nops[3] = '{15, 13, 5};
        k = int'($urandom_range(0, 9));
        fsel = int'($urandom_range(0, 5));
        off = (int'($urandom_range(0, 31)) - 8) * 4;
        case (k)
            0, 1, 2: return enc_r($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), fns[fsel]);
            4:       return enc_i(35, 0, $urandom_range(0, 7), off);
            5:       return enc_i(43, 0, $urandom_range(0, 7), off);
            6:       return enc_i(4, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3));
            7:       return enc_i(nops[fsel % 3], $urandom_range(0, 7), $urandom_range(0, 7), $urandom());
            default: return enc_i(8, $urandom_range(0, 7), $urandom_range(1, 7), $urandom());
        endcase
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        int n;
        logic [31:0] w;
        do_reset();
        snap(32, 32'h0, "reset_pc");
        snap(33, 32'h0, "reset_rdata_ext");
        snap(34, 32'h0, "reset_rdata_ext_2");
        snap(5, 32'h0, "reset_reg5");

        // addi then STOP
        do_reset();
        prog.delete();
        prog.push_back(enc_i(8, 0, 16, 7));
        prog.push_back(enc_stop(0));
        load_prog();
        run_prog(0, "addi");
        snap(16, 32'h7, "addi_r16");
        snap(32, 32'h4, "addi_stop_pc");

        // lw / sw round trip
        do_reset();
        dmem_write(0, 32'd9);
        prog.delete();
        prog.push_back(enc_i(35, 0, 18, 0));
        prog.push_back(enc_i(43, 0, 18, 4));
        prog.push_back(enc_i(35, 0, 18, 4));
        prog.push_back(enc_stop(0));
        load_prog();
        run_prog(0, "lwsw");
        snap(18, 32'h9, "lwsw_r18");
        dmem_read(1, 32'h9, "lwsw_dmem1");

        // R-type ALU on 7 and 9, plus signed slt and a discarded $0 write
        do_reset();
        prog.delete();
        prog.push_back(enc_i(8, 0, 16, 7));
        prog.push_back(enc_i(8, 0, 18, 9));
        prog.push_back(enc_r(16, 18, 19, 32));
        prog.push_back(enc_r(16, 18, 20, 34));
        prog.push_back(enc_r(16, 18, 21, 36));
        prog.push_back(enc_r(16, 18, 22, 37));
        prog.push_back(enc_r(16, 18, 23, 42));
        prog.push_back(enc_r(18, 16, 24, 42));
        prog.push_back(enc_i(8, 0, 5, -3));
        prog.push_back(enc_r(5, 16, 6, 42));
        prog.push_back(enc_r(16, 18, 0, 32));
        prog.push_back(enc_stop(2));
        load_prog();
        run_prog(0, "alu");
        snap(19, 32'h10, "alu_add");
        snap(20, 32'hFFFF_FFFE, "alu_sub");
        snap(21, 32'h1, "alu_and");
        snap(22, 32'hF, "alu_or");
        snap(23, 32'h1, "alu_slt_true");
        snap(24, 32'h0, "alu_slt_false");
        snap(6, 32'h1, "alu_slt_signed");
        snap(0, 32'h0, "alu_r0_discard");

        // beq taken and not taken
        for (int t = 0; t < 2; t++) begin
            do_reset();
            prog.delete();
            prog.push_back(enc_i(8, 0, 16, 7));
            prog.push_back(enc_i(8, 0, 17, (t == 0) ? 7 : 8));
            prog.push_back(enc_i(4, 16, 17, 1));
            prog.push_back(enc_i(8, 0, 20, 1));
            prog.push_back(enc_i(8, 20, 21, 0));
            prog.push_back(enc_i(8, 0, 20, 25));
            prog.push_back(enc_stop(0));
            load_prog();
            run_prog(0, (t == 0) ? "beq_taken" : "beq_not");
            snap(20, 32'h19, "beq_r20");
            snap(21, (t == 0) ? 32'h0 : 32'h1, "beq_skipped_marker");
        end

        // j over a poisoned instruction, then mul 19*10
        do_reset();
        prog.delete();
        prog.push_back(enc_i(8, 0, 10, 19));
        prog.push_back(enc_i(8, 0, 11, 10));
        prog.push_back(enc_j(4));
        prog.push_back(enc_i(8, 0, 9, 1));
        prog.push_back(enc_r(10, 11, 9, 24));
        prog.push_back(enc_stop(1));
        load_prog();
        run_prog(0, "mulj");
        snap(9, 32'hBE, "mul_r9");
        snap(32, 32'h14, "mulj_stop_pc");

        // external ports: load, read back, ignored writes while enabled, hold, reset
        for (int i = 0; i < 4; i++) begin
            imem_write(100 + i, $urandom() | 32'h1);
            dmem_write(200 + i, $urandom() | 32'h1);
        end
        for (int i = 0; i < 4; i++) begin
            imem_read(100 + i, m_imem[100 + i], "ext_imem_rd");
            dmem_read(200 + i, m_dmem[200 + i], "ext_dmem_rd");
        end
        enable = 1'b1;
        addr_ext = 32'(100 * 4); wdata_ext = ~m_imem[100]; wen_ext = 1'b1;
        addr_ext_2 = 32'(200 * 4); wdata_ext_2 = ~m_dmem[200]; wen_ext_2 = 1'b1;
        tick(); tick();
        enable = 1'b0; wen_ext = 1'b0; wen_ext_2 = 1'b0;
        tick();
        dmem_read(200, m_dmem[200], "ext_dmem_wen_while_enabled");
        imem_read(100, m_imem[100], "ext_imem_wen_while_enabled");
        tick(); tick();
        snap(33, m_imem[100], "ext_rdata_hold");
        snap(34, m_dmem[200], "ext_rdata_2_hold");
        do_reset();
        snap(33, 32'h0, "ext_rdata_reset");
        snap(34, 32'h0, "ext_rdata_2_reset");

        // reset asserted mid-run, then the same program from the top
        prog.delete();
        for (int i = 1; i <= 8; i++) prog.push_back(enc_i(8, i - 1, i, 11));
        prog.push_back(enc_stop(3));
        load_prog();
        enable = 1'b1;
        tick(); tick(); tick();
        arst_n = 1'b0;
        tick();
        arst_n = 1'b1; enable = 1'b0;
        snap(32, 32'h0, "midrst_pc");
        snap(1, 32'h0, "midrst_reg1");
        snap(2, 32'h0, "midrst_reg2");
        run_prog(0, "midrst_rerun");
        snap(8, 32'd88, "midrst_reg8");

        // randomized programs with flickering enable
        for (int p = 0; p < 8; p++) begin
            do_reset();
            n = int'($urandom_range(12, 30));
            prog.delete();
            for (int i = 0; i < n; i++) prog.push_back(rand_instr());
            for (int t = 0; t < 4; t++) prog.push_back(enc_stop(t));
            load_prog();
            for (int i = 0; i < 24; i++) dmem_write(i, $urandom());
            for (int i = DMEM_SIZE - 8; i < DMEM_SIZE; i++) dmem_write(i, $urandom());
            run_prog(1, $sformatf("rand%0d", p));
            for (int i = 0; i < prog.size(); i++) begin
                w = m_imem[i];
                imem_read(i, w, "rand_imem");
            end
            for (int i = 0; i < 24; i++) dmem_read(i, m_dmem[i], $sformatf("rand_dmem%0d", i));
            for (int i = DMEM_SIZE - 8; i < DMEM_SIZE; i++) dmem_read(i, m_dmem[i], $sformatf("rand_dmem%0d", i));
        end

        tick(); tick(); tick();
        if (rd_q.size() + rd2_q.size() + st_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", rd_q.size() + rd2_q.size() + st_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
